plab2_proc_mem_arbiter: RTL



---
 rtl/plab2_proc_mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/plab2_proc_mem_arbiter.sv
// Two-to-one imem/dmem request arbiter with a one-entry request stage, per-port
// outstanding limits, domain tagging and source-tag based response steering.
module plab2_proc_mem_arbiter #(
  parameter int p_max_outstanding = 4,
  parameter int p_req_nbits       = 77,
  parameter int p_resp_nbits      = 45
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  imemreq_msg,
  input  logic                    imemreq_val,
  output logic                    imemreq_rdy,
  input  logic                    imemreq_domain,

  input  logic [p_req_nbits-1:0]  dmemreq_msg,
  input  logic                    dmemreq_val,
  output logic                    dmemreq_rdy,
  input  logic                    dmemreq_domain,

  output logic [p_resp_nbits-1:0] imemresp_msg,
  output logic                    imemresp_val,
  input  logic                    imemresp_rdy,

  output logic [p_resp_nbits-1:0] dmemresp_msg,
  output logic                    dmemresp_val,
  input  logic                    dmemresp_rdy,

  output logic [p_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,
  output logic                    memreq_domain,

  input  logic [p_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy,

  output logic                    resp_err
);

  // Handshake: a transfer happens on a rising clk edge where val && rdy are
  // both high; val/msg are held by the sender until that edge.

  localparam int CW       = $clog2(p_max_outstanding + 1);
  localparam int REQ_TAG  = p_req_nbits - 4;   // opaque[7] in a request
  localparam int RESP_TAG = p_resp_nbits - 4;  // opaque[7] in a response
  localparam logic [CW:0] MAX_CNT = (CW + 1)'(p_max_outstanding);

  logic                   stage_val;
  logic [p_req_nbits-1:0] stage_msg;
  logic                   stage_domain;
  logic                   stage_src;
  logic                   last_grant;
  logic [CW-1:0]          icnt;
  logic [CW-1:0]          dcnt;

  logic          can_accept;
  logic          i_staged, d_staged;
  logic [CW:0]   i_pend, d_pend;
  logic          i_elig, d_elig;
  logic          i_gnt, d_gnt;
  logic          i_acc, d_acc, acc;
  logic [p_req_nbits-1:0] acc_msg;
  logic          acc_domain;
  logic          req_fire;
  logic          resp_dst, resp_drop, drop_fire;
  logic [p_resp_nbits-1:0] fwd_msg;
  logic          i_inc, i_dec, d_inc, d_dec;

  assign can_accept = !stage_val || memreq_rdy;

  // A request sitting in the stage is already in flight from its port's point
  // of view, so it counts against the limit before it reaches memory.
  assign i_staged = stage_val && !stage_src;
  assign d_staged = stage_val &&  stage_src;
  assign i_pend   = {1'b0, icnt} + {{CW{1'b0}}, i_staged};
  assign d_pend   = {1'b0, dcnt} + {{CW{1'b0}}, d_staged};
  assign i_elig   = imemreq_val && (i_pend < MAX_CNT);
  assign d_elig   = dmemreq_val && (d_pend < MAX_CNT);

  assign i_gnt = i_elig && (!d_elig ||  last_grant);
  assign d_gnt = d_elig && (!i_elig || !last_grant);

  assign imemreq_rdy = reset && i_gnt && can_accept;
  assign dmemreq_rdy = reset && d_gnt && can_accept;

  assign i_acc      = imemreq_val && imemreq_rdy;
  assign d_acc      = dmemreq_val && dmemreq_rdy;
  assign acc        = i_acc || d_acc;
  assign acc_msg    = d_acc ? dmemreq_msg : imemreq_msg;
  assign acc_domain = d_acc ? dmemreq_domain : imemreq_domain;

  assign memreq_val    = stage_val;
  assign memreq_msg    = stage_msg;
  assign memreq_domain = stage_domain;
  assign req_fire      = stage_val && memreq_rdy;

  // Responses whose port has nothing outstanding are swallowed and flagged.
  assign resp_dst  = memresp_msg[RESP_TAG];
  assign resp_drop = resp_dst ? (dcnt == '0) : (icnt == '0);
  assign fwd_msg   = {memresp_msg[p_resp_nbits-1:RESP_TAG+1], 1'b0,
                      memresp_msg[RESP_TAG-1:0]};

  assign imemresp_msg = fwd_msg;
  assign dmemresp_msg = fwd_msg;
  assign imemresp_val = reset && memresp_val && !resp_dst && !resp_drop;
  assign dmemresp_val = reset && memresp_val &&  resp_dst && !resp_drop;
  assign memresp_rdy  = reset && (resp_drop || (resp_dst ? dmemresp_rdy : imemresp_rdy));
  assign drop_fire    = memresp_val && memresp_rdy && resp_drop;

  assign i_inc = req_fire && !stage_src;
  assign d_inc = req_fire &&  stage_src;
  assign i_dec = imemresp_val && imemresp_rdy;
  assign d_dec = dmemresp_val && dmemresp_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_val    <= 1'b0;
      stage_msg    <= '0;
      stage_domain <= 1'b0;
      stage_src    <= 1'b0;
      last_grant   <= 1'b1;
      icnt         <= '0;
      dcnt         <= '0;
      resp_err     <= 1'b0;
    end else begin
      if (acc) begin
        stage_val    <= 1'b1;
        stage_msg    <= {acc_msg[p_req_nbits-1:REQ_TAG+1], d_acc, acc_msg[REQ_TAG-1:0]};
        stage_domain <= acc_domain;
        stage_src    <= d_acc;
        last_grant   <= d_acc;
      end else if (req_fire) begin
        stage_val <= 1'b0;
      end

      case ({i_inc, i_dec})
        2'b10:   icnt <= icnt + CW'(1);
        2'b01:   icnt <= icnt - CW'(1);
        default: icnt <= icnt;
      endcase

      case ({d_inc, d_dec})
        2'b10:   dcnt <= dcnt + CW'(1);
        2'b01:   dcnt <= dcnt - CW'(1);
        default: dcnt <= dcnt;
      endcase

      // Registered so the drop indication is a clean one-cycle pulse.
      resp_err <= drop_fire;
    end
  end

endmodule
